// File: rtl/cordic_kernel_iter_pkg.sv
// rtl/cordic_kernel_iter_pkg.sv - shared CORDIC mode/state types and iteration limits
package package_settings;

  localparam int MAX_CORDIC_ITERATIONS = 32;
  localparam int CORDIC_IDX_W          = $clog2(MAX_CORDIC_ITERATIONS);

  typedef enum logic {
    CORDIC_ROTATE = 1'b0,
    CORDIC_VECTOR = 1'b1
  } cordic_mode_t;

  typedef enum logic [1:0] {
    CORDIC_IDLE,
    CORDIC_ITER,
    CORDIC_DONE
  } cordic_iter_state_t;

endpackage

// File: rtl/cordic_kernel_iter_if.sv
// rtl/cordic_kernel_iter_if.sv - sample/result handshake bundle of the iterative CORDIC kernel
interface cordic_kernel_iter_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int TAG_WIDTH   = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_mode;
  logic signed [DATA_WIDTH-1:0] in_x;
  logic signed [DATA_WIDTH-1:0] in_y;
  logic [ANGLE_WIDTH-1:0]       in_z;
  logic [TAG_WIDTH-1:0]         in_tag;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH+1:0] out_x;
  logic signed [DATA_WIDTH+1:0] out_y;
  logic [ANGLE_WIDTH-1:0]       out_z;
  logic [TAG_WIDTH-1:0]         out_tag;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_tag
  );
endinterface

// File: rtl/cordic_kernel_iter_atan_rom.sv
// rtl/cordic_kernel_iter_atan_rom.sv - elaboration-time atan(2^-i) table in binary angle units
module cordic_atan_rom
  import package_settings::*;
#(
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 16
) (
  input  logic [CORDIC_IDX_W-1:0] idx,
  output logic [ANGLE_WIDTH-1:0]  atan
);

  // Rounded atan(2^-i) with a full turn equal to 2^32; narrower angles round this down.
  function automatic logic [31:0] atan_ref32(input int i);
    case (i)
      0:  return 32'h2000_0000;
      1:  return 32'h12E4_051E;
      2:  return 32'h09FB_385B;
      3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;
      5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;
      7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;
      9:  return 32'h0014_5F2F;
      10: return 32'h000A_2F98;
      11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;
      13: return 32'h0001_45F3;
      14: return 32'h0000_A2FA;
      15: return 32'h0000_517D;
      16: return 32'h0000_28BE;
      17: return 32'h0000_145F;
      18: return 32'h0000_0A30;
      19: return 32'h0000_0518;
      20: return 32'h0000_028C;
      21: return 32'h0000_0146;
      22: return 32'h0000_00A3;
      23: return 32'h0000_0051;
      24: return 32'h0000_0029;
      25: return 32'h0000_0014;
      26: return 32'h0000_000A;
      27: return 32'h0000_0005;
      28: return 32'h0000_0003;
      29: return 32'h0000_0001;
      30: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [ANGLE_WIDTH-1:0] scale_angle(input logic [31:0] v);
    logic [32:0] t;
    t = {1'b0, v};
    if (ANGLE_WIDTH < 32) t = t + (33'd1 << (31 - ANGLE_WIDTH));
    t = t >> (32 - ANGLE_WIDTH);
    return t[ANGLE_WIDTH-1:0];
  endfunction

  logic [ANGLE_WIDTH-1:0] atan_table [MAX_CORDIC_ITERATIONS];

  for (genvar g = 0; g < MAX_CORDIC_ITERATIONS; g++) begin : g_entry
    if (g < ITERATIONS) begin : g_used
      assign atan_table[g] = scale_angle(atan_ref32(g));
    end else begin : g_unused
      assign atan_table[g] = '0;
    end
  end

  assign atan = atan_table[idx];

endmodule

// File: rtl/cordic_kernel_iter.sv
// rtl/cordic_kernel_iter.sv - iterative rotation/vectoring CORDIC kernel, one micro-rotation per cycle
module cordic_kernel_iter
  import package_settings::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 16,
  parameter int TAG_WIDTH   = 4
) (
  input logic                clk,
  input logic                reset,
  cordic_kernel_iter_if.slave bus
);

  localparam int XW = DATA_WIDTH + 2;
  localparam logic [CORDIC_IDX_W-1:0] LAST_IDX  = CORDIC_IDX_W'(ITERATIONS - 1);
  localparam logic [ANGLE_WIDTH-1:0]  HALF_TURN = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

  if (ITERATIONS < 1 || ITERATIONS > ANGLE_WIDTH || ITERATIONS > DATA_WIDTH + 2 ||
      ITERATIONS > MAX_CORDIC_ITERATIONS || ANGLE_WIDTH < 2 || ANGLE_WIDTH > 32) begin : g_bad_params
    $error("cordic_kernel_iter: illegal ITERATIONS/ANGLE_WIDTH/DATA_WIDTH combination");
  end

  cordic_iter_state_t        state_q, state_d;
  cordic_mode_t              mode_q, mode_d;
  logic [CORDIC_IDX_W-1:0]   count_q, count_d;
  logic signed [XW-1:0]      x_q, x_d, y_q, y_d;
  logic [ANGLE_WIDTH-1:0]    z_q, z_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [XW-1:0]      x_in, y_in, x_sh, y_sh;
  logic                      flip, sigma_pos;
  logic [ANGLE_WIDTH-1:0]    atan_i;

  cordic_atan_rom #(
    .ANGLE_WIDTH (ANGLE_WIDTH),
    .ITERATIONS  (ITERATIONS)
  ) u_atan_rom (
    .idx  (count_q),
    .atan (atan_i)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    tag_d       = tag_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    x_in = {{2{bus.in_x[DATA_WIDTH-1]}}, bus.in_x};
    y_in = {{2{bus.in_y[DATA_WIDTH-1]}}, bus.in_y};
    // Fold the input into the right half-plane so the micro-rotations can converge.
    flip = bus.in_mode ? bus.in_x[DATA_WIDTH-1]
                       : (bus.in_z[ANGLE_WIDTH-1] ^ bus.in_z[ANGLE_WIDTH-2]);
    sigma_pos = (mode_q == CORDIC_ROTATE) ? !z_q[ANGLE_WIDTH-1] : y_q[XW-1];
    x_sh = x_q >>> count_q;
    y_sh = y_q >>> count_q;

    case (state_q)
      CORDIC_IDLE: begin
        if (bus.in_valid) begin
          mode_d     = bus.in_mode ? CORDIC_VECTOR : CORDIC_ROTATE;
          tag_d      = bus.in_tag;
          x_d        = flip ? -x_in : x_in;
          y_d        = flip ? -y_in : y_in;
          z_d        = flip ? bus.in_z + HALF_TURN : bus.in_z;
          count_d    = '0;
          in_ready_d = 1'b0;
          state_d    = CORDIC_ITER;
        end
      end
      CORDIC_ITER: begin
        if (sigma_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        if (count_q == LAST_IDX) begin
          state_d     = CORDIC_DONE;
          out_valid_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      CORDIC_DONE: begin
        if (bus.out_ready) begin
          state_d     = CORDIC_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = CORDIC_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CORDIC_IDLE;
      mode_q      <= CORDIC_ROTATE;
      count_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      tag_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      tag_q       <= tag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_z     = z_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_cordic_kernel_iter.sv
// tb/tb_cordic_kernel_iter.sv - scoreboard bench for the iterative CORDIC kernel
module tb_cordic_kernel_iter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 16;
  localparam int TW = 4;

  typedef struct {
    string       name;
    logic [3:0]  tag;
    int          x;
    int          y;
    logic [15:0] z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_xfer = 0;
  exp_t sb[$];
  int   xfer_cyc[$];

  cordic_kernel_iter_if #(.DATA_WIDTH(DW), .ANGLE_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

  cordic_kernel_iter #(
    .DATA_WIDTH (DW),
    .ANGLE_WIDTH(AW),
    .ITERATIONS (N),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int got, input int want, input int tol);
    int d;
    n_cmp++;
    d = got - want;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, got, want, tol);
    end
  endtask

  task automatic chk_ang(input string name, input logic [15:0] got, input logic [15:0] want, input int tol);
    logic signed [15:0] d;
    int ad;
    n_cmp++;
    d  = got - want;
    ad = (d < 0) ? -int'(d) : int'(d);
    if (ad > tol) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h, want 16'h%04h (tol %0d)", name, got, want, tol);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        n_xfer++;
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk_int("unexpected result tag", int'(bus.out_tag), -1, 0);
        end else begin
          e = sb.pop_front();
          chk_int({e.name, " x"}, int'(bus.out_x), e.x, 4);
          chk_int({e.name, " y"}, int'(bus.out_y), e.y, 4);
          chk_ang({e.name, " z"}, bus.out_z, e.z, 2);
          chk_int({e.name, " tag"}, int'(bus.out_tag), int'(e.tag), 0);
        end
      end
    end
  end

  task automatic send(input string name, input logic mode, input int x, input int y,
                      input logic [15:0] z, input logic [3:0] tag,
                      input int ex, input int ey, input logic [15:0] ez);
    exp_t e;
    bit   ok;
    bus.in_mode  = mode;
    bus.in_x     = 16'(x);
    bus.in_y     = 16'(y);
    bus.in_z     = z;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_int({name, " accept timeout"}, 0, 1, 0);
    e.name = name; e.tag = tag; e.x = ex; e.y = ey; e.z = ez;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cycles_seen);
    cycles_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      cycles_seen++;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    chk_int({name, " drained"}, sb.size(), 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ka, lat, base;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_int("reset in_ready", int'(bus.in_ready), 1, 0);
    chk_int("reset out_valid", int'(bus.out_valid), 0, 0);
    chk_int("reset out_x", int'(bus.out_x), 0, 0);
    chk_int("reset out_y", int'(bus.out_y), 0, 0);
    chk_int("reset out_z", int'(bus.out_z), 0, 0);
    chk_int("reset out_tag", int'(bus.out_tag), 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Rotation by pi/4, with latency measured from the accept edge.
    send("rot45", 1'b0, 10000, 0, 16'h2000, 4'h1, 11645, 11645, 16'h0000);
    ka = cyc;
    bus.in_valid = 1'b0;
    chk_int("in_ready after accept", int'(bus.in_ready), 0, 0);
    wait_valid(lat);
    chk_int("latency cycles", cyc - ka + 1, N + 1, 0);
    drain("rot45");

    send("vec_y", 1'b1, 0, 10000, 16'h0000, 4'h2, 16468, 0, 16'h4000);
    send("vec_negx", 1'b1, -10000, 0, 16'h0000, 4'h3, 16468, 0, 16'h8000);
    send("rot_m90", 1'b0, 10000, 0, 16'hC000, 4'h4, 0, -16468, 16'h0000);
    send("rot_p90", 1'b0, 10000, 0, 16'h4000, 4'h5, 0, 16468, 16'h0000);
    bus.in_valid = 1'b0;
    drain("directed");

    // Backpressure: result held for 5 cycles while a second sample waits.
    bus.out_ready = 1'b0;
    send("stall", 1'b0, 10000, 0, 16'h2000, 4'h6, 11645, 11645, 16'h0000);
    bus.in_mode = 1'b1; bus.in_x = 16'sd0; bus.in_y = 16'sd10000; bus.in_z = '0; bus.in_tag = 4'h9;
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      chk_int("stall out_valid", int'(bus.out_valid), 1, 0);
      chk_int("stall out_x", int'(bus.out_x), 11645, 0);
      chk_int("stall out_y", int'(bus.out_y), 11645, 0);
      chk_int("stall out_z", int'(bus.out_z), 0, 0);
      chk_int("stall out_tag", int'(bus.out_tag), 6, 0);
      chk_int("stall in_ready", int'(bus.in_ready), 0, 0);
      @(posedge clk);
      #1;
    end
    chk_int("stall results pending", sb.size(), 1, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_int("release out_valid", int'(bus.out_valid), 0, 0);
    chk_int("release in_ready", int'(bus.in_ready), 1, 0);
    send("after_stall", 1'b1, 0, 10000, 16'h0000, 4'h9, 16468, 0, 16'h4000);
    bus.in_valid = 1'b0;
    drain("stall");

    // Back-to-back with in_valid held high.
    base = xfer_cyc.size();
    send("b2b3", 1'b0, 10000, 0, 16'h2000, 4'h3, 11645, 11645, 16'h0000);
    send("b2b7", 1'b1, 0, 10000, 16'h0000, 4'h7, 16468, 0, 16'h4000);
    send("b2bA", 1'b1, -10000, 0, 16'h0000, 4'hA, 16468, 0, 16'h8000);
    bus.in_valid = 1'b0;
    drain("b2b");
    chk_int("b2b result count", xfer_cyc.size() - base, 3, 0);
    if (xfer_cyc.size() - base == 3) begin
      chk_int("b2b spacing 1", xfer_cyc[base+1] - xfer_cyc[base], N + 2, 0);
      chk_int("b2b spacing 2", xfer_cyc[base+2] - xfer_cyc[base+1], N + 2, 0);
    end

    // Reset in the middle of iterating drops the sample.
    send("dropped", 1'b0, 10000, 0, 16'h2000, 4'hB, 11645, 11645, 16'h0000);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    chk_int("midreset out_valid", int'(bus.out_valid), 0, 0);
    chk_int("midreset in_ready", int'(bus.in_ready), 1, 0);
    chk_int("midreset out_x", int'(bus.out_x), 0, 0);
    chk_int("midreset out_y", int'(bus.out_y), 0, 0);
    chk_int("midreset out_z", int'(bus.out_z), 0, 0);
    chk_int("midreset out_tag", int'(bus.out_tag), 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send("post_reset", 1'b0, 10000, 0, 16'hC000, 4'hC, 0, -16468, 16'h0000);
    bus.in_valid = 1'b0;
    drain("post_reset");

    chk_int("total results", n_xfer, 11, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
